// File: rtl/pattern_ctrl_pkg.sv
// Shared key indices, state/field encodings and the speed-adjust helper for
// the pattern controller.
package pattern_ctrl_pkg;

  localparam int unsigned KEY_UP   = 0;
  localparam int unsigned KEY_DOWN = 1;
  localparam int unsigned KEY_SEL  = 2;
  localparam int unsigned KEY_AUTO = 3;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_e;

  typedef enum logic {
    FIELD_PAT = 1'b0,
    FIELD_SPD = 1'b1
  } field_e;

  localparam logic [1:0] SPEED_MIN = 2'd0;
  localparam logic [1:0] SPEED_MAX = 2'd3;

  // Saturating speed step; callers guarantee up and down are not both set.
  function automatic logic [1:0] speed_adjust(input logic [1:0] spd,
                                              input logic       up,
                                              input logic       down);
    logic [1:0] res;
    res = spd;
    if (up && (spd != SPEED_MAX)) begin
      res = spd + 2'd1;
    end else if (down && (spd != SPEED_MIN)) begin
      res = spd - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pattern_ctrl_auto_timer.sv
// Auto-step timer: counts 0..(AUTO_PERIOD>>period_shift)-1 while enabled and
// flags the terminal count combinationally.
module auto_timer #(
  parameter int unsigned AUTO_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] period_shift,
  output logic       tc
);

  localparam int unsigned CntW = $clog2(AUTO_PERIOD);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] last_cnt;

  assign last_cnt = CntW'((AUTO_PERIOD >> period_shift) - 1);
  assign tc       = enable && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_ctrl.sv
// Display pattern controller: manual up/down editing of pattern or speed, and
// an auto mode that steps the pattern at a speed-dependent period.
module pattern_ctrl
  import pattern_ctrl_pkg::*;
#(
  parameter int unsigned PATTERN_NUM = 8,
  parameter int unsigned AUTO_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_pulse,
  output logic [2:0] pattern_idx,
  output logic [1:0] speed,
  output logic       field_sel,
  output logic       auto_mode,
  output logic       step_pulse
);

  localparam logic [2:0] PatLast = 3'(PATTERN_NUM - 1);

  state_e     state_q, state_d;
  field_e     field_q, field_d;
  logic [2:0] pat_q, pat_d;
  logic [1:0] spd_q, spd_d;
  logic       step_q, step_d;

  logic key_up, key_down, key_sel, key_auto;
  logic up_only, down_only;
  logic timer_en, timer_clr, timer_tc;

  assign key_up    = key_pulse[KEY_UP];
  assign key_down  = key_pulse[KEY_DOWN];
  assign key_sel   = key_pulse[KEY_SEL];
  assign key_auto  = key_pulse[KEY_AUTO];
  assign up_only   = key_up && !key_down;
  assign down_only = key_down && !key_up;

  function automatic logic [2:0] pat_inc(input logic [2:0] p);
    return (p == PatLast) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [2:0] pat_dec(input logic [2:0] p);
    return (p == 3'd0) ? PatLast : p - 3'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    pat_d   = pat_q;
    spd_d   = spd_q;

    // Priority: auto > sel > up/down; lower-priority keys are dropped.
    if (key_auto) begin
      state_d = (state_q == AUTO) ? MANUAL : AUTO;
    end else if (key_sel) begin
      if (state_q == MANUAL) begin
        field_d = (field_q == FIELD_PAT) ? FIELD_SPD : FIELD_PAT;
      end
    end else if (up_only || down_only) begin
      if ((state_q == AUTO) || (field_q == FIELD_SPD)) begin
        spd_d = speed_adjust(spd_q, up_only, down_only);
      end else begin
        pat_d = up_only ? pat_inc(pat_q) : pat_dec(pat_q);
      end
    end

    // In AUTO up/down never touch the pattern, so the timer step cannot collide.
    if ((state_q == AUTO) && timer_tc && !key_auto) begin
      pat_d = pat_inc(pat_q);
    end

    step_d = (pat_d != pat_q);
  end

  assign timer_en  = (state_q == AUTO);
  assign timer_clr = ((state_q == MANUAL) && (state_d == AUTO)) || (spd_d != spd_q);

  auto_timer #(
    .AUTO_PERIOD (AUTO_PERIOD)
  ) u_auto_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (timer_en),
    .clear        (timer_clr),
    .period_shift (spd_q),
    .tc           (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      field_q <= FIELD_PAT;
      pat_q   <= 3'd0;
      spd_q   <= 2'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      pat_q   <= pat_d;
      spd_q   <= spd_d;
      step_q  <= step_d;
    end
  end

  assign pattern_idx = pat_q;
  assign speed       = spd_q;
  assign field_sel   = field_q;
  assign auto_mode   = (state_q == AUTO);
  assign step_pulse  = step_q;

endmodule

// File: tb/tb_pattern_ctrl.sv
// Scoreboard bench for pattern_ctrl: a behavioural model predicts each cycle's
// outputs into a queue that an independent monitor pops and compares.
module tb_pattern_ctrl;

  localparam int PN = 8;
  localparam int AP = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_pulse;
  logic [2:0] pattern_idx;
  logic [1:0] speed;
  logic       field_sel;
  logic       auto_mode;
  logic       step_pulse;

  pattern_ctrl #(
    .PATTERN_NUM (PN),
    .AUTO_PERIOD (AP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pulse   (key_pulse),
    .pattern_idx (pattern_idx),
    .speed       (speed),
    .field_sel   (field_sel),
    .auto_mode   (auto_mode),
    .step_pulse  (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pat;
    logic [1:0] spd;
    logic       fsel;
    logic       auto;
    logic       step;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests;
  int   n_fail;
  bit   mon_en;

  // Reference state: what the DUT should show in the cycle after the last key.
  int m_pat, m_spd, m_fsel, m_auto, m_age;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pat  = 0;
    m_spd  = 0;
    m_fsel = 0;
    m_auto = 0;
    m_age  = 0;
  endtask

  // Drive one key vector for the current cycle and predict the next outputs.
  task automatic apply(input logic [3:0] k);
    int   n_pat, n_spd, n_fsel, n_auto, n_age;
    bit   due;
    obs_t e;
    key_pulse = k;
    n_pat  = m_pat;
    n_spd  = m_spd;
    n_fsel = m_fsel;
    n_auto = m_auto;
    // m_age is the number of whole auto cycles already spent in this period.
    due = (m_auto == 1) && (m_age + 1 == (AP >> m_spd));
    if (k[3]) begin
      n_auto = 1 - m_auto;
    end else if (k[2]) begin
      if (m_auto == 0) n_fsel = 1 - m_fsel;
    end else if (k[0] != k[1]) begin
      if (m_auto == 1 || m_fsel == 1) begin
        if (k[0]) n_spd = (m_spd < 3) ? m_spd + 1 : 3;
        else      n_spd = (m_spd > 0) ? m_spd - 1 : 0;
      end else begin
        if (k[0]) n_pat = (m_pat + 1) % PN;
        else      n_pat = (m_pat + PN - 1) % PN;
      end
    end
    if (due && !k[3]) n_pat = (m_pat + 1) % PN;
    if ((m_auto == 0 && n_auto == 1) || n_spd != m_spd) n_age = 0;
    else if (m_auto == 1) n_age = due ? 0 : m_age + 1;
    else n_age = 0;
    e.pat  = 3'(n_pat);
    e.spd  = 2'(n_spd);
    e.fsel = 1'(n_fsel);
    e.auto = 1'(n_auto);
    e.step = (n_pat != m_pat);
    exp_q.push_back(e);
    m_pat  = n_pat;
    m_spd  = n_spd;
    m_fsel = n_fsel;
    m_auto = n_auto;
    m_age  = n_age;
  endtask

  task automatic drive(input logic [3:0] k);
    @(negedge clk);
    apply(k);
  endtask

  task automatic drive_sample(input logic [3:0] k);
    drive(k);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every registered output sample against the queue head.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n) begin
        a = {pattern_idx, speed, field_sel, auto_mode, step_pulse};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: got %h expected queued entry", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard {pat,spd,fsel,auto,step}: got %h expected %h", a, e);
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pattern"}, int'(pattern_idx), 0);
    chk({tag, "_speed"}, int'(speed), 0);
    chk({tag, "_field"}, int'(field_sel), 0);
    chk({tag, "_auto"}, int'(auto_mode), 0);
    chk({tag, "_step"}, int'(step_pulse), 0);
  endtask

  task automatic measure_step(input string name, input int exp_cycles);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    while (!got && cyc < 64) begin
      drive_sample(4'b0000);
      cyc++;
      if (step_pulse) got = 1;
    end
    chk(name, cyc, exp_cycles);
  endtask

  initial begin
    int pat_before;
    int guard;
    logic [3:0] k;
    n_tests   = 0;
    n_fail    = 0;
    mon_en    = 0;
    rst_n     = 1'b0;
    key_pulse = 4'b0000;
    model_reset();
    #12;
    chk_all_zero("reset");

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    apply(4'b0000);

    // Three manual ups.
    for (int i = 1; i <= 3; i++) begin
      drive_sample(4'b0001);
      chk("manual_up_pattern", int'(pattern_idx), i);
      chk("manual_up_step", int'(step_pulse), 1);
    end
    repeat (3) drive(4'b0010);
    drive_sample(4'b0010);
    chk("down_wrap_0_to_7", int'(pattern_idx), 7);
    drive_sample(4'b0001);
    chk("up_wrap_7_to_0", int'(pattern_idx), 0);

    // Speed editing with saturation.
    drive_sample(4'b0100);
    chk("sel_field", int'(field_sel), 1);
    for (int i = 1; i <= 5; i++) begin
      drive_sample(4'b0001);
      chk("speed_sat", int'(speed), (i < 3) ? i : 3);
    end
    chk("speed_edit_pattern_hold", int'(pattern_idx), 0);
    repeat (3) drive(4'b0010);

    // Auto stepping.
    drive_sample(4'b1000);
    chk("auto_entry", int'(auto_mode), 1);
    measure_step("auto_first_step_cycles", 16);
    measure_step("auto_period_cycles", 16);
    drive(4'b0001);
    drive_sample(4'b0001);
    chk("auto_speed2", int'(speed), 2);
    measure_step("auto_speed2_period", 4);

    // Simultaneous keys.
    drive_sample(4'b1000);
    chk("auto_exit", int'(auto_mode), 0);
    pat_before = int'(pattern_idx);
    drive_sample(4'b0011);
    chk("updown_pattern_hold", int'(pattern_idx), pat_before);
    chk("updown_speed_hold", int'(speed), 2);
    chk("updown_no_step", int'(step_pulse), 0);
    drive_sample(4'b1001);
    chk("auto_up_mode", int'(auto_mode), 1);
    chk("auto_up_speed_hold", int'(speed), 2);
    drive(4'b0010);
    drive(4'b0010);

    // Asynchronous reset mid-AUTO with the timer at 10.
    guard = 0;
    while (m_age != 10 && guard < 100) begin
      drive(4'b0000);
      guard++;
    end
    chk("timer_reach_10", m_age, 10);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    mon_en = 0;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    model_reset();
    key_pulse = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    apply(4'b0000);
    repeat (30) drive(4'b0000);

    // Key in the first cycle after release.
    @(negedge clk);
    rst_n  = 1'b0;
    mon_en = 0;
    exp_q.delete();
    model_reset();
    key_pulse = 4'b0000;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    apply(4'b0001);
    @(posedge clk);
    #1;
    chk("post_reset_key_pattern", int'(pattern_idx), 1);
    chk("post_reset_key_step", int'(step_pulse), 1);

    // Randomized traffic; auto toggles kept rare so the timer gets to fire.
    repeat (3000) begin
      k = ($urandom_range(0, 9) < 6) ? 4'b0000 : 4'($urandom_range(0, 15));
      if (k[3] && $urandom_range(0, 3) != 0) k[3] = 1'b0;
      drive(k);
    end
    drive(4'b0000);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
